// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : IF-stage front end: PC, imem address, IF/ID register, redirect
//            and stall/flush handling, HALT trap on out-of-range fetches.
//            Optional macro FETCH_PERF_CNT_EN adds fetch/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 10,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] Inst,
    output logic [31:0] Addr,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misalign_err,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    // Limit is kept 34 bits wide so a memory covering the full 4 GiB space
    // still compares correctly against a 32-bit PC.
    localparam logic [33:0] c_pc_limit = 34'(IMEM_WORDS) * 34'd4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_halted;
    logic        r_misalign;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc_plus4_d;
    logic        r_valid_d;

    logic        w_in_range;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_tgt;
    logic        w_load;

    assign w_in_range     = ({2'b00, r_pc} < c_pc_limit);
    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign w_load         = (r_state == ST_RUN) && w_in_range && !redirect_valid;

    // PC / HALT controller; redirect always wins, even over stall_f
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            case (r_state)
                ST_RUN: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_tgt;
                    end else if (stall_f) begin
                        r_pc <= r_pc;
                    end else if (!w_in_range) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
                ST_HALT: begin
                    if (redirect_valid) begin
                        r_pc     <= w_redirect_tgt;
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush > stall_d > fetch > bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else if (flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b0;
        end else if (!stall_d) begin
            r_instr_d    <= w_load ? Inst : NOP_INSTR;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= w_load;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;
    logic        w_fetch_evt;
    logic        w_bubble_evt;

    assign w_fetch_evt  = !flush_d && !stall_d && w_load;
    assign w_bubble_evt = flush_d || (!stall_d && !w_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_fetch_evt) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_bubble_evt) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

    assign Addr         = r_pc;
    assign instr_d      = r_instr_d;
    assign pc_d         = r_pc_d;
    assign pc_plus4_d   = r_pc_plus4_d;
    assign valid_d      = r_valid_d;
    assign misalign_err = r_misalign;
    assign halted       = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage with a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_nop        = 32'h0000_0013;
    localparam logic [31:0] c_imem_bytes = 32'd40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] Inst;
    logic [31:0] Addr, instr_d, pc_d, pc_plus4_d;
    logic        valid_d, misalign_err, halted;

    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'd0;
    logic [31:0] w_inst_c = 32'hABCD_0001;
    logic [31:0] w_addr, w_instr_d, w_pc_d, w_pc4_d;
    logic        w_valid_d, w_mis, w_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, bubble_cnt, w_fcnt, w_bcnt;
`endif

    logic [31:0] mem [16];

    always #5 clk = ~clk;
    always_comb Inst = mem[Addr[5:2]];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(10), .NOP_INSTR(c_nop)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .Inst(Inst), .Addr(Addr),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .misalign_err(misalign_err), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    // Second instance covering the whole address space to exercise PC wrap
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(32'h4000_0000), .NOP_INSTR(c_nop)) u_wrap (
        .clk(clk), .rst(rst), .stall_f(w_zero), .stall_d(w_zero),
        .flush_d(w_zero), .redirect_valid(w_zero),
        .redirect_pc(w_zero32), .Inst(w_inst_c), .Addr(w_addr),
        .instr_d(w_instr_d), .pc_d(w_pc_d), .pc_plus4_d(w_pc4_d),
        .valid_d(w_valid_d), .misalign_err(w_mis), .halted(w_halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(w_fcnt), .bubble_cnt(w_bcnt)
`endif
    );

    typedef struct {
        logic [31:0] addr, instr, pcd, pc4, fcnt, bcnt;
        logic        valid, mis, halted;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: fetch pointer, trap flag, and the IF/ID contents
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fcnt, m_bcnt;
    logic        m_halt, m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_halt = 1'b0; m_instr = c_nop; m_pcd = 32'd0;
        m_pc4 = 32'd0; m_valid = 1'b0; m_fcnt = 32'd0; m_bcnt = 32'd0;
    endtask

    // Apply one cycle of inputs, predict the post-edge state, push it, then
    // let the edge happen. Returns 2 time units after the rising edge.
    task automatic step(input bit sf, input bit sd, input bit fl, input bit rv,
                        input logic [31:0] rp);
        exp_t e;
        bit   fetchable;
        stall_f = sf; stall_d = sd; flush_d = fl;
        redirect_valid = rv; redirect_pc = rp;
        fetchable = !m_halt && (m_pc < c_imem_bytes) && !rv;
        if (fl) begin
            m_instr = c_nop; m_valid = 1'b0; m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
            m_bcnt++;
        end else if (!sd) begin
            if (fetchable) begin
                m_instr = mem[m_pc[5:2]]; m_valid = 1'b1;
                m_pcd = m_pc; m_pc4 = m_pc + 32'd4;
                m_fcnt++;
            end else begin
                m_instr = c_nop; m_valid = 1'b0;
                m_bcnt++;
            end
        end
        if (rv) begin
            m_pc = rp & 32'hFFFF_FFFC;
            m_halt = 1'b0;
        end else if (!m_halt && !sf) begin
            if (m_pc < c_imem_bytes) m_pc = m_pc + 32'd4;
            else m_halt = 1'b1;
        end
        e.addr = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4 = m_pc4;
        e.valid = m_valid; e.mis = rv && (rp[1:0] != 2'b00); e.halted = m_halt;
        e.fcnt = m_fcnt; e.bcnt = m_bcnt;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge with a pending prediction is compared
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("addr", Addr, e.addr);
            chk("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
            chk("instr_d", instr_d, e.instr);
            if (e.valid) begin
                chk("pc_d", pc_d, e.pcd);
                chk("pc_plus4_d", pc_plus4_d, e.pc4);
            end
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            chk("halted", {31'd0, halted}, {31'd0, e.halted});
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt, e.fcnt);
            chk("bubble_cnt", bubble_cnt, e.bcnt);
`endif
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_addr"}, Addr, 32'd0);
        chk({tag, "_instr_d"}, instr_d, c_nop);
        chk({tag, "_pc_d"}, pc_d, 32'd0);
        chk({tag, "_pc4_d"}, pc_plus4_d, 32'd0);
        chk({tag, "_valid_d"}, {31'd0, valid_d}, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
        chk({tag, "_bubble_cnt"}, bubble_cnt, 32'd0);
`endif
    endtask

    task automatic rand_steps(input int n);
        logic [31:0] rp;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) rp = $urandom;
            else rp = ($urandom_range(0, 11) << 2) |
                      (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, rp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        model_reset();
        #12;
        chk_reset_values("reset");
        chk("wrap_reset_addr", w_addr, 32'hFFFF_FFFC);
        #10;                              // t=22, between edges
        rst = 1'b0;

        // Straight-line fetch 0..36, then the fetch at 40 traps
        step(0, 0, 0, 0, 0);
        chk("wrap_addr", w_addr, 32'd0);
        chk("wrap_valid", {31'd0, w_valid_d}, 32'd1);
        chk("wrap_instr", w_instr_d, 32'hABCD_0001);
        chk("wrap_pc_d", w_pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", w_pc4_d, 32'd0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_after_run", fetch_cnt, 32'd10);
`endif
        // Leave HALT via redirect to 8, then fetch mem[2]
        step(0, 0, 0, 1, 32'd8);
        step(0, 0, 0, 0, 0);
        // PC=12: stall both stages for three cycles
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Misaligned redirect with flush
        step(0, 0, 1, 1, 32'h0000_0006);
        step(0, 0, 0, 0, 0);
        // Flush beats stall_d
        step(0, 1, 1, 0, 0);
        // Out-of-range redirect re-enters HALT
        step(0, 0, 0, 1, 32'h0000_0100);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Redirect with stall_d and no flush: PC moves, IF/ID holds
        step(0, 1, 0, 1, 32'd20);
        step(0, 0, 0, 0, 0);

        rand_steps(600);

        // Reach HALT, then assert reset between clock edges
        step(0, 0, 1, 1, 32'd36);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("halted_before_async_rst", {31'd0, halted}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_values("async_rst");
        model_reset();
        #2;
        rst = 1'b0;
        rand_steps(100);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
